// File: rtl/vram_pkg.sv
// Shared types for the video RAM arbiter: slot owner tags and CPU port states.
package vram_pkg;

  localparam int SCREEN_W_DEF = 800;
  localparam int SCREEN_H_DEF = 600;

  function automatic int fb_words(input int w, input int h);
    return w * h;
  endfunction

  localparam int FB_WORDS = fb_words(SCREEN_W_DEF, SCREEN_H_DEF);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_ISSUE = 2'd1,
    C_RDATA = 2'd2,
    C_ACK   = 2'd3
  } cpu_state_e;

endpackage

// File: rtl/pixel_addr_gen.sv
// Pixel (x, y) to linear framebuffer address, with an on-screen flag.
module pixel_addr_gen #(
  parameter int COORDINATES = 10,
  parameter int ADDR_W      = 19,
  parameter int SCREEN_W    = 800,
  parameter int SCREEN_H    = 600
) (
  input  logic [COORDINATES-1:0] x,
  input  logic [COORDINATES-1:0] y,
  output logic [ADDR_W-1:0]      addr,
  output logic                   in_range
);

  localparam logic [COORDINATES:0] W_LIM = (COORDINATES+1)'(SCREEN_W);
  localparam logic [COORDINATES:0] H_LIM = (COORDINATES+1)'(SCREEN_H);

  always_comb begin
    addr     = ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);
    in_range = ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM owner: display scan-out gets every slot it asks for,
// the CPU port takes the remaining slots through a req/ack handshake.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int COORDINATES = 10,
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int ADDR_W      = 19
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   disp_req,
  input  logic [COORDINATES-1:0] disp_x,
  input  logic [COORDINATES-1:0] disp_y,
  output logic                   disp_valid,
  output logic [DATA_W-1:0]      disp_data,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic                   cpu_ack,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_err,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata
);

  localparam logic [ADDR_W:0] FB_LIM = (ADDR_W+1)'(fb_words(SCREEN_W, SCREEN_H));

  logic [ADDR_W-1:0] pix_addr;
  logic              pix_inr;

  pixel_addr_gen #(
    .COORDINATES (COORDINATES),
    .ADDR_W      (ADDR_W),
    .SCREEN_W    (SCREEN_W),
    .SCREEN_H    (SCREEN_H)
  ) u_pix (
    .x        (disp_x),
    .y        (disp_y),
    .addr     (pix_addr),
    .in_range (pix_inr)
  );

  logic              disp_slot, cpu_inr, cpu_grant;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  owner_e            slot_own_q, slot_own_d;
  owner_e            rd_own_q;
  logic [1:0]        disp_vld_q, disp_vld_d;
  cpu_state_e        state_q, state_d;
  logic              op_we_q, op_we_d;
  logic              op_err_q, op_err_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              cpu_err_q, cpu_err_d;

  // Slot scheduler: an off-screen display request leaves the slot to the CPU.
  always_comb begin
    disp_slot   = disp_req & pix_inr;
    cpu_inr     = {1'b0, cpu_addr} < FB_LIM;
    cpu_grant   = (state_q == C_IDLE) & cpu_req & ~disp_slot;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    slot_own_d  = OWN_NONE;
    if (disp_slot) begin
      mem_addr_d = pix_addr;
      slot_own_d = OWN_DISP;
    end else if (cpu_grant && cpu_inr) begin
      mem_addr_d = cpu_addr;
      mem_we_d   = cpu_we;
      slot_own_d = OWN_CPU;
      if (cpu_we) mem_wdata_d = cpu_wdata;
    end
    disp_vld_d = {disp_vld_q[0], disp_req};
  end

  always_comb begin
    state_d     = state_q;
    op_we_d     = op_we_q;
    op_err_d    = op_err_q;
    cpu_rdata_d = cpu_rdata_q;
    case (state_q)
      C_IDLE: begin
        if (cpu_grant) begin
          state_d  = C_ISSUE;
          op_we_d  = cpu_we;
          op_err_d = ~cpu_inr;
        end
      end
      C_ISSUE: state_d = op_we_q ? C_ACK : C_RDATA;
      C_RDATA: begin
        // Out-of-range reads never owned the slot, so they return zero.
        cpu_rdata_d = (rd_own_q == OWN_CPU) ? mem_rdata : '0;
        state_d     = C_ACK;
      end
      C_ACK:   state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
    cpu_ack_d = (state_d == C_ACK);
    cpu_err_d = (state_d == C_ACK) & op_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      slot_own_q  <= OWN_NONE;
      rd_own_q    <= OWN_NONE;
      disp_vld_q  <= '0;
      state_q     <= C_IDLE;
      op_we_q     <= 1'b0;
      op_err_q    <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      slot_own_q  <= slot_own_d;
      rd_own_q    <= slot_own_q;
      disp_vld_q  <= disp_vld_d;
      state_q     <= state_d;
      op_we_q     <= op_we_d;
      op_err_q    <= op_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_err_q   <= cpu_err_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign disp_valid = disp_vld_q[1];
  assign disp_data  = (disp_vld_q[1] && rd_own_q == OWN_DISP) ? mem_rdata : '0;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_err    = cpu_err_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: cycle-indexed expectation model plus literal pins.
module tb_vram_arbiter;

  logic        clk, rst_n;
  logic        disp_req;
  logic [9:0]  disp_x, disp_y;
  logic        disp_valid;
  logic [15:0] disp_data;
  logic        cpu_req, cpu_we;
  logic [18:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack, cpu_err;
  logic [15:0] cpu_rdata;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  vram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical RAM driven by the DUT; shadow is the model's own view of memory.
  logic [15:0] ram    [0:524287];
  logic [15:0] shadow [0:524287];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  // Expectations indexed by cycle number (cycle n follows the n-th clock edge).
  bit        exp_dv    [0:4095];
  bit [15:0] exp_dd    [0:4095];
  bit        exp_ack   [0:4095];
  bit        exp_err   [0:4095];
  bit        exp_rdupd [0:4095];
  bit [15:0] exp_rdval [0:4095];
  bit        exp_mwe   [0:4095];
  bit [18:0] exp_maddr [0:4095];
  bit [15:0] exp_mwd   [0:4095];

  int        cyc = 0;
  int        n_m, p_m, pa_m, ack_m, cpu_free;
  bit        pix_ok_m, d_slot_m, oor_m, we_m;
  bit [18:0] m_addr;
  bit [15:0] m_wd;

  initial begin
    cpu_free = 0;
    m_addr   = '0;
    m_wd     = '0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      n_m = cyc;
      p_m = n_m - 1;
      we_m = 1'b0;
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) begin
          exp_dv[n_m+k] = 0; exp_dd[n_m+k] = 0; exp_ack[n_m+k] = 0;
          exp_err[n_m+k] = 0; exp_rdupd[n_m+k] = 0;
        end
        m_addr = '0; m_wd = '0; cpu_free = 0;
      end else begin
        pix_ok_m = (disp_x < 10'd800) && (disp_y < 10'd600);
        d_slot_m = disp_req && pix_ok_m;
        if (disp_req) begin
          pa_m = int'(disp_y) * 800 + int'(disp_x);
          exp_dv[p_m+2] = 1'b1;
          exp_dd[p_m+2] = pix_ok_m ? shadow[pa_m] : 16'h0;
          if (pix_ok_m) m_addr = 19'(pa_m);
        end
        if (cpu_req && p_m >= cpu_free && !d_slot_m) begin
          oor_m = int'(cpu_addr) >= 480000;
          ack_m = cpu_we ? p_m + 2 : p_m + 3;
          exp_ack[ack_m] = 1'b1;
          exp_err[ack_m] = oor_m;
          cpu_free = ack_m + 1;
          if (!cpu_we) begin
            exp_rdupd[ack_m] = 1'b1;
            exp_rdval[ack_m] = oor_m ? 16'h0 : shadow[cpu_addr];
          end
          if (!oor_m) begin
            m_addr = cpu_addr;
            if (cpu_we) begin
              we_m = 1'b1;
              m_wd = cpu_wdata;
              shadow[cpu_addr] = cpu_wdata;
            end
          end
        end
      end
      exp_maddr[n_m] = m_addr;
      exp_mwd[n_m]   = m_wd;
      exp_mwe[n_m]   = we_m;
    end
  end

  logic [15:0] rd_hold = '0;
  bit          e_dv, e_ack, e_err, e_mwe;
  bit [15:0]   e_dd, e_mwd;
  bit [18:0]   e_maddr;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (!rst_n) begin
          rd_hold = '0;
          e_dv = 0; e_dd = 0; e_ack = 0; e_err = 0; e_mwe = 0; e_maddr = 0; e_mwd = 0;
        end else begin
          if (exp_rdupd[cyc]) rd_hold = exp_rdval[cyc];
          e_dv = exp_dv[cyc]; e_dd = exp_dd[cyc]; e_ack = exp_ack[cyc]; e_err = exp_err[cyc];
          e_mwe = exp_mwe[cyc]; e_maddr = exp_maddr[cyc]; e_mwd = exp_mwd[cyc];
        end
        chk("m_disp_valid", 32'(disp_valid), 32'(e_dv));
        chk("m_disp_data",  32'(disp_data),  32'(e_dd));
        chk("m_cpu_ack",    32'(cpu_ack),    32'(e_ack));
        chk("m_cpu_err",    32'(cpu_err),    32'(e_err));
        chk("m_cpu_rdata",  32'(cpu_rdata),  32'(rd_hold));
        chk("m_mem_we",     32'(mem_we),     32'(e_mwe));
        chk("m_mem_addr",   32'(mem_addr),   32'(e_maddr));
        chk("m_mem_wdata",  32'(mem_wdata),  32'(e_mwd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wait(output int n);
    n = 0;
    while (!cpu_ack && n < 20) begin
      tick();
      n++;
    end
    chk("ack_seen", 32'(cpu_ack), 1);
    cpu_req = 1'b0;
  endtask

  task automatic cpu_set(input bit we, input logic [18:0] a, input logic [15:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  int lat, acks;

  initial begin
    for (int i = 0; i < 524288; i++) begin
      ram[i]    = 16'(i) ^ 16'h5A5A;
      shadow[i] = 16'(i) ^ 16'h5A5A;
    end
    ram[1605] = 16'h07E0;
    shadow[1605] = 16'h07E0;
    rst_n = 1'b0;
    disp_req = 1'b0; disp_x = '0; disp_y = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_ack", 32'(cpu_ack), 0);
    chk("rst_disp_valid", 32'(disp_valid), 0);
    rst_n = 1'b1;
    tick(); tick();

    // CPU write while the display is idle
    cpu_set(1'b1, 19'h10, 16'hF800);
    tick();
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", 32'(mem_addr), 'h10);
    chk("wr_mem_wdata", 32'(mem_wdata), 'hF800);
    tick();
    chk("wr_ack", 32'(cpu_ack), 1);
    chk("wr_err", 32'(cpu_err), 0);
    cpu_req = 1'b0;
    tick(); tick();

    // Display read of (5,2)
    disp_req = 1'b1; disp_x = 10'd5; disp_y = 10'd2;
    tick();
    chk("dr_mem_addr", 32'(mem_addr), 1605);
    chk("dr_mem_we", 32'(mem_we), 0);
    disp_req = 1'b0;
    tick();
    chk("dr_valid", 32'(disp_valid), 1);
    chk("dr_data", 32'(disp_data), 'h07E0);
    tick(); tick();

    // Display and CPU read in the same cycle
    disp_req = 1'b1; disp_x = 10'd3; disp_y = 10'd0;
    cpu_set(1'b0, 19'h100, 16'h0);
    tick();
    disp_req = 1'b0;
    chk("col_disp_addr", 32'(mem_addr), 3);
    tick();
    chk("col_cpu_addr", 32'(mem_addr), 'h100);
    cpu_wait(lat);
    chk("col_latency", 32'(lat + 2), 4);
    chk("col_rdata", 32'(cpu_rdata), 'h5B5A);
    tick(); tick();

    // Four display slots in a row hold off a pending CPU write
    cpu_set(1'b1, 19'h20, 16'h1234);
    for (int k = 0; k < 4; k++) begin
      disp_req = 1'b1; disp_x = 10'(10 + k); disp_y = 10'd1;
      tick();
      chk("stv_no_we", 32'(mem_we), 0);
    end
    disp_req = 1'b0;
    tick();
    chk("stv_we", 32'(mem_we), 1);
    chk("stv_addr", 32'(mem_addr), 'h20);
    cpu_wait(lat);
    chk("stv_ack_lat", 32'(lat), 1);
    tick(); tick();

    // Off-screen CPU write and read
    cpu_set(1'b1, 19'd480000, 16'hBEEF);
    cpu_wait(lat);
    chk("oorw_lat", 32'(lat), 2);
    chk("oorw_err", 32'(cpu_err), 1);
    tick();
    cpu_set(1'b0, 19'h7FFFF, 16'h0);
    cpu_wait(lat);
    chk("oorr_lat", 32'(lat), 3);
    chk("oorr_err", 32'(cpu_err), 1);
    chk("oorr_rdata", 32'(cpu_rdata), 0);
    tick();

    // Off-screen display request
    disp_req = 1'b1; disp_x = 10'd800; disp_y = 10'd0;
    tick();
    disp_req = 1'b0;
    chk("oord_we", 32'(mem_we), 0);
    chk("oord_addr_hold", 32'(mem_addr), 'h20);
    tick();
    chk("oord_valid", 32'(disp_valid), 1);
    chk("oord_data", 32'(disp_data), 0);
    tick();

    // Plain read of the first write
    cpu_set(1'b0, 19'h10, 16'h0);
    cpu_wait(lat);
    chk("rd_lat", 32'(lat), 3);
    chk("rd_rdata", 32'(cpu_rdata), 'hF800);
    tick(); tick();

    // Reset while a read sits in its data-capture cycle
    cpu_set(1'b0, 19'h40, 16'h0);
    tick(); tick();
    #1;
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("mr_mem_addr", 32'(mem_addr), 0);
    chk("mr_mem_we", 32'(mem_we), 0);
    chk("mr_mem_wdata", 32'(mem_wdata), 0);
    chk("mr_cpu_rdata", 32'(cpu_rdata), 0);
    chk("mr_cpu_ack", 32'(cpu_ack), 0);
    chk("mr_cpu_err", 32'(cpu_err), 0);
    chk("mr_disp", 32'({disp_valid, disp_data}), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (cpu_ack) acks++;
    end
    chk("mr_no_ack", 32'(acks), 0);

    // Recovery: a fresh write and read back
    cpu_set(1'b1, 19'h30, 16'h00AA);
    cpu_wait(lat);
    chk("rc_wr_lat", 32'(lat), 2);
    tick();
    cpu_set(1'b0, 19'h30, 16'h0);
    cpu_wait(lat);
    chk("rc_rdata", 32'(cpu_rdata), 'h00AA);
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
